// File: rtl/bat_loader_pkg.sv
// Shared definitions for the bat_amateur boot loader: state codes, strobe
// polarities and stream framing constants.
package bat_loader_pkg;
  typedef logic [3:0] state_t;

  localparam state_t S_IDLE    = 4'd0;
  localparam state_t S_HDR_HI  = 4'd1;
  localparam state_t S_HDR_LO  = 4'd2;
  localparam state_t S_DATA_HI = 4'd3;
  localparam state_t S_DATA_LO = 4'd4;
  localparam state_t S_WRITE   = 4'd5;
  localparam state_t S_CHECK   = 4'd6;
  localparam state_t S_DONE    = 4'd7;
  localparam state_t S_ERR     = 4'd8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_IDLE  = 1'b0;
  localparam logic EN_ON    = 1'b1;
  localparam logic EN_OFF   = 1'b0;

  localparam int HDR_BYTES = 2;
  localparam int CSUM_W    = 8;

  function automatic logic is_rx_state(input state_t s);
    return s inside {S_HDR_HI, S_HDR_LO, S_DATA_HI, S_DATA_LO, S_CHECK};
  endfunction
endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog for the loader byte stream; limit of 0 disables it.
module loader_timeout (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clear,
  input  logic        en,
  input  logic [15:0] limit,
  output logic        expired
);
  logic [15:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)       cnt <= 16'd0;
    else if (clear) cnt <= 16'd0;
    else if (en)    cnt <= cnt + 16'd1;
  end

  // Fires during the limit-th idle cycle so the owner's state lands in ERR on that edge.
  assign expired = en && (limit != 16'd0) && (cnt == limit - 16'd1);
endmodule

// File: rtl/program_loader.sv
// Boot loader: holds bat_amateur in HALT, streams a word-count header plus
// big-endian words into core RAM, then releases HALT. Optional trailing
// XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader
  import bat_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter logic [15:0] IDLE_TIMEOUT = 16'd0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic        HALT,
  output logic [15:0] ADDRESS,
  output logic        ADDR_OE,
  output logic [15:0] BUS_OUT,
  output logic        BUS_OE,
  output logic        EXT_RAM_RW,
  output logic        EXT_RAM_EN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR
);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHECK;
  logic [CSUM_W-1:0] csum;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t      state, state_nx;
  logic [7:0]  hdr_hi;
  logic [15:0] rem;
  logic        accept, expired, to_clear;

  always_comb begin
    accept   = RX_VALID & RX_READY;
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (START) state_nx = S_HDR_HI;
      S_HDR_HI:  if (accept) state_nx = S_HDR_LO;
      S_HDR_LO:  if (accept) state_nx = ({hdr_hi, RX_DATA} == 16'd0) ? S_END : S_DATA_HI;
      S_DATA_HI: if (accept) state_nx = S_DATA_LO;
      S_DATA_LO: if (accept) state_nx = S_WRITE;
      S_WRITE:   state_nx = (rem == 16'd1) ? S_END : S_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:   if (accept) state_nx = (csum == RX_DATA) ? S_DONE : S_ERR;
`endif
      default:   state_nx = S_IDLE;
    endcase
    if (RX_READY && !accept && expired) state_nx = S_ERR;
    to_clear = accept | ((state_nx == S_HDR_HI) && (state != S_HDR_HI));
  end

  loader_timeout u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (to_clear),
    .en      (RX_READY),
    .limit   (IDLE_TIMEOUT),
    .expired (expired)
  );

  assign ADDR_OE = HALT;

  // Status and strobes are registered off the next state so no input reaches an output combinationally.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      RX_READY   <= 1'b0;
      HALT       <= 1'b1;
      ADDRESS    <= BASE_ADDR;
      BUS_OUT    <= 16'd0;
      BUS_OE     <= EN_OFF;
      EXT_RAM_RW <= RW_IDLE;
      EXT_RAM_EN <= EN_OFF;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
      hdr_hi     <= 8'd0;
      rem        <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_nx;
      RX_READY   <= is_rx_state(state_nx);
      HALT       <= (state_nx != S_DONE);
      BUSY       <= !(state_nx inside {S_IDLE, S_DONE, S_ERR});
      DONE       <= (state_nx == S_DONE);
      ERROR      <= (state_nx == S_ERR);
      EXT_RAM_EN <= (state_nx == S_WRITE) ? EN_ON : EN_OFF;
      EXT_RAM_RW <= (state_nx == S_WRITE) ? RW_WRITE : RW_IDLE;
      BUS_OE     <= (state_nx == S_WRITE) ? EN_ON : EN_OFF;
      case (state)
        S_IDLE, S_DONE, S_ERR: if (START) ADDRESS <= BASE_ADDR;
        S_HDR_HI:  if (accept) hdr_hi <= RX_DATA;
        S_HDR_LO:  if (accept) rem <= {hdr_hi, RX_DATA};
        S_DATA_HI: if (accept) BUS_OUT[15:8] <= RX_DATA;
        S_DATA_LO: if (accept) BUS_OUT[7:0] <= RX_DATA;
        S_WRITE: begin
          ADDRESS <= ADDRESS + 16'd1;
          rem     <= rem - 16'd1;
        end
        default: ;
      endcase
`ifdef LOADER_CHECKSUM_EN
      if ((state inside {S_IDLE, S_DONE, S_ERR}) && START) csum <= '0;
      else if (accept && state != S_CHECK)                 csum <= csum ^ RX_DATA;
`endif
    end
  end
endmodule
